l1_dram_arbiter: RTL and testbench
==================================

Name: l1_dram_arbiter

Overview:
- Shares the single external DRAM port between the L1 instruction-cache controller and the L1 data-cache controller.
- Each requester drives the same cs/we/ack protocol that a cache controller uses toward DRAM; the arbiter grants one at a time, holds the grant until the DRAM acks, then releases.
- Round-robin on simultaneous requests; a watchdog aborts grants the DRAM never acknowledges.

Parameters:
ADDR_W, 32, byte address width of DRAM requests
LINE_W, 256, cache line width in bits (DRAM data bus)
TIMEOUT, 1024, max cycles a grant may wait for dram_ack before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
i_cs  in  1  I-cache DRAM request
i_we  in  1  I-cache write (write-back) when 1, read when 0
i_addr  in  ADDR_W  I-cache line address
i_wdata  in  LINE_W  I-cache write line
i_ack  out  1  ack to I-cache
d_cs  in  1  D-cache DRAM request
d_we  in  1  D-cache write when 1
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write line
d_ack  out  1  ack to D-cache
rdata  out  LINE_W  DRAM read line, broadcast to both caches
dram_cs  out  1  DRAM chip select
dram_we  out  1  DRAM write enable
dram_addr  out  ADDR_W  DRAM address
dram_wdata  out  LINE_W  DRAM write data
dram_rdata  in  LINE_W  DRAM read data
dram_ack  in  1  DRAM completion
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, last_grant=D, watchdog count=0, err_timeout=0, dram_cs=dram_we=0, dram_addr/dram_wdata=0. Reset mid-grant drops dram_cs at that edge; no ack is forwarded.
- States: IDLE, GRANT_I, GRANT_D, RELEASE (2-bit encoding).
- IDLE: on posedge, only i_cs -> GRANT_I; only d_cs -> GRANT_D; both -> grant the requester not equal to last_grant (after reset, I wins the first tie). Otherwise stay.
- Entering GRANT_x: latch x_we, x_addr, x_wdata into dram_we/dram_addr/dram_wdata registers and assert dram_cs. Latency is 1 cycle from request sampled to dram_cs high. last_grant<=x.
- GRANT_x: dram_cs held high with latched fields; requester input changes are ignored. x_ack = dram_ack (combinational, gated by state); the other ack is 0. rdata = dram_rdata at all times.
- GRANT_x with dram_ack=1 at posedge -> RELEASE; dram_cs<=0; watchdog cleared.
- RELEASE: exactly one cycle, no grants, both acks 0. This lets the requester drop cs and prevents a stale cs from being re-granted. Then -> IDLE.
- Watchdog: counts cycles in GRANT_x without dram_ack. If the count reaches TIMEOUT-1 with no ack, it sets err_timeout, forces RELEASE, and drops dram_cs. It pulses x_ack for that cycle so the requester FSM cannot hang; read data is then undefined. err_timeout clears only on reset. The counter width is clog2(TIMEOUT).
- An ack on the same edge as the timeout counts as a normal ack; err_timeout is not set.
- dram_ack while IDLE or RELEASE is ignored.
- Back-to-back: with both requesters held high continuously, grants alternate I,D,I,D. Each transaction occupies 1 grant cycle + DRAM latency + 1 RELEASE cycle.

Decomposition:
- State encodings and the I/D grant constants go in a shared state-table header alongside the cache controller states, with distinct macro names.
- The natural sub-module is l1_dram_watchdog: counter plus clear, enable, and expire pulse, parameterised by TIMEOUT.
- The round-robin pick stays inline.

Test Plan:
- Reset, then i_cs=1, i_we=0, i_addr=0x100. Required: dram_cs=1, dram_addr=0x100 one cycle later. DRAM acks after 5 cycles: i_ack=1 for 1 cycle, d_ack stays 0, rdata=dram_rdata. Then RELEASE, IDLE.
- i_cs and d_cs asserted in the same cycle right after reset. Required: I granted first, D granted after I's RELEASE, and dram_we/addr switch to D's values.
- Both held high for 4 transactions. Required: grant order I,D,I,D; no cycle with dram_cs high outside GRANT states.
- During GRANT_D, change d_addr from 0x200 to 0x300. Required: dram_addr stays 0x200 until the ack.
- DRAM never acks, TIMEOUT=8. Required: after 7 grant cycles, err_timeout=1, a 1-cycle x_ack pulse, dram_cs=0. err_timeout stays 1 until rst=0.
- rst=0 for one edge mid-GRANT_I. Required: next cycle dram_cs=0, state IDLE, no i_ack, err_timeout=0.

Source files
------------

// File: rtl/l1_dram_arbiter_pkg.sv
// Shared encodings for the L1 <-> DRAM arbiter: FSM states and grant owners.
// Prefixed names keep them apart from the cache-controller state tables.
package l1_dram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_GNT_I = 1'b0,
    ARB_GNT_D = 1'b1
  } arb_gnt_e;

  function automatic logic arb_is_grant(arb_state_e s);
    return (s == ARB_GRANT_I) || (s == ARB_GRANT_D);
  endfunction

endpackage

// File: rtl/l1_dram_arbiter_watchdog.sv
// Grant watchdog: counts unacknowledged grant cycles and flags the last one.
// expire_o is combinational so the owner can be acked in the same cycle.
module l1_dram_arbiter_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) cnt_d = '0;
    else if (en_i)         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/l1_dram_arbiter.sv
// Arbitrates the single DRAM port between I-cache and D-cache controllers.
// One owner at a time, round-robin on ties, one idle RELEASE cycle per transaction.
module l1_dram_arbiter
  import l1_dram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cs,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_ack,
  input  logic              d_cs,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] rdata,
  output logic              dram_cs,
  output logic              dram_we,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [LINE_W-1:0] dram_wdata,
  input  logic [LINE_W-1:0] dram_rdata,
  input  logic              dram_ack,
  output logic              err_timeout
);

  arb_state_e        state_q, state_d;
  arb_gnt_e          last_q, last_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic in_grant, wd_en, wd_clr, wd_expire, done, pick_i;

  assign in_grant = arb_is_grant(state_q);
  assign wd_en    = in_grant && !dram_ack;
  assign wd_clr   = !wd_en;
  assign done     = in_grant && (dram_ack || wd_expire);

  l1_dram_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  // Tie goes to whoever did not own the port last.
  assign pick_i = i_cs && (!d_cs || (last_q == ARB_GNT_D));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cs_d    = cs_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_cs || d_cs) begin
          cs_d = 1'b1;
          if (pick_i) begin
            state_d = ARB_GRANT_I;
            last_d  = ARB_GNT_I;
            we_d    = i_we;
            addr_d  = i_addr;
            wdata_d = i_wdata;
          end else begin
            state_d = ARB_GRANT_D;
            last_d  = ARB_GNT_D;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        if (done) begin
          state_d = ARB_RELEASE;
          cs_d    = 1'b0;
          err_d   = err_q | wd_expire;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_GNT_D;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // A watchdog expiry acks the owner too, so its FSM never hangs.
  assign i_ack       = (state_q == ARB_GRANT_I) && (dram_ack || wd_expire);
  assign d_ack       = (state_q == ARB_GRANT_D) && (dram_ack || wd_expire);
  assign rdata       = dram_rdata;
  assign dram_cs     = cs_q;
  assign dram_we     = we_q;
  assign dram_addr   = addr_q;
  assign dram_wdata  = wdata_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_l1_dram_arbiter.sv
// Randomized bench for l1_dram_arbiter against a transaction-owner reference model.
module tb_l1_dram_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cs, i_we, d_cs, d_we, dram_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata, dram_rdata;
  logic          i_ack, d_ack, dram_cs, dram_we, err_timeout;
  logic [AW-1:0] dram_addr;
  logic [LW-1:0] rdata, dram_wdata;

  always #5 clk = ~clk;

  l1_dram_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_ack(i_ack),
    .d_cs(d_cs), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .rdata(rdata), .dram_cs(dram_cs), .dram_we(dram_we), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .dram_ack(dram_ack),
    .err_timeout(err_timeout)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D), cool-down flag,
  // the captured request, cycles already spent waiting, and the sticky error.
  int            owner, waited, grants_i, grants_d;
  bit            cool, last_was_i, m_err, fresh;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    owner = 0; waited = 0; cool = 0; last_was_i = 0; m_err = 0; fresh = 1;
    m_we = 0; m_addr = '0; m_wdata = '0;
  endtask

  task automatic take(input int who);
    owner = who; waited = 0; fresh = 0;
    last_was_i = (who == 1);
    if (who == 1) begin m_we = i_we; m_addr = i_addr; m_wdata = i_wdata; grants_i++; end
    else          begin m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; grants_d++; end
  endtask

  // Check outputs mid-cycle, then advance the model at the clock edge.
  task automatic cycle();
    bit tmo;
    @(negedge clk);
    tmo = (owner != 0) && !dram_ack && (waited == TO - 1);
    chk("dram_cs", dram_cs, owner != 0);
    chk("i_ack", i_ack, (owner == 1) && (dram_ack || tmo));
    chk("d_ack", d_ack, (owner == 2) && (dram_ack || tmo));
    chk("err_timeout", err_timeout, m_err);
    chk("rdata", rdata, dram_rdata);
    if (owner != 0 || fresh) begin
      chk("dram_we", dram_we, m_we);
      chk("dram_addr", dram_addr, m_addr);
      chk("dram_wdata", dram_wdata, m_wdata);
    end
    @(posedge clk);
    if (!rst) model_reset();
    else if (owner != 0) begin
      if (dram_ack || tmo) begin owner = 0; cool = 1; m_err |= tmo; end
      else waited++;
    end else if (cool) cool = 0;
    else if (i_cs && d_cs) take(last_was_i ? 2 : 1);
    else if (i_cs) take(1);
    else if (d_cs) take(2);
    #1;
  endtask

  task automatic drive(input bit r, input bit ic, input bit dc, input bit ack,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da);
    rst = r; i_cs = ic; d_cs = dc; dram_ack = ack; i_addr = ia; d_addr = da;
    i_we = $urandom_range(1); d_we = $urandom_range(1);
    i_wdata = rnd_line(); d_wdata = rnd_line(); dram_rdata = rnd_line();
  endtask

  task automatic rand_cycle(input int p_cs, input int p_ack, input int p_rst);
    drive($urandom_range(99) >= p_rst, $urandom_range(99) < p_cs, $urandom_range(99) < p_cs,
          $urandom_range(99) < p_ack, $urandom, $urandom);
    cycle();
  endtask

  initial begin
    int gi0;
    grants_i = 0; grants_d = 0;
    drive(0, 0, 0, 0, '0, '0);
    @(posedge clk); model_reset(); #1;
    cycle();
    // single I read at 0x100, acked after 5 grant cycles
    drive(1, 1, 0, 0, 32'h100, 32'h0); cycle();
    for (int k = 0; k < 4; k++) begin drive(1, 1, 0, 0, 32'h100, 32'h0); cycle(); end
    chk("dir_addr_0x100", dram_addr, 32'h100);
    drive(1, 1, 0, 1, 32'h100, 32'h0); cycle();
    for (int k = 0; k < 3; k++) begin drive(1, 0, 0, 0, 32'h0, 32'h0); cycle(); end
    // simultaneous request after reset: I first, then D; D address change ignored
    drive(0, 0, 0, 0, '0, '0); cycle();
    gi0 = grants_i;
    drive(1, 1, 1, 0, 32'h100, 32'h200); cycle();
    chk("tie_i_first", grants_i - gi0, 1);
    drive(1, 0, 1, 1, 32'h100, 32'h200); cycle();
    for (int k = 0; k < 2; k++) begin drive(1, 0, 1, 0, 32'h0, 32'h200); cycle(); end
    for (int k = 0; k < 3; k++) begin drive(1, 0, 1, 0, 32'h0, 32'h300); cycle(); end
    chk("hold_addr_0x200", dram_addr, 32'h200);
    drive(1, 0, 1, 1, 32'h0, 32'h300); cycle();
    drive(1, 0, 0, 0, 32'h0, 32'h0); cycle();
    // reset pulse in the middle of an I grant
    drive(1, 1, 0, 0, 32'h40, 32'h0); cycle(); cycle();
    drive(0, 1, 0, 1, 32'h40, 32'h0); cycle();
    drive(1, 0, 0, 1, 32'h40, 32'h0); cycle();
    // both held high: grants must alternate
    gi0 = grants_i - grants_d;
    for (int k = 0; k < 80; k++) begin
      drive(1, 1, 1, $urandom_range(99) < 30, $urandom, $urandom); cycle();
    end
    chk("alternation", (grants_i - grants_d - gi0 + 1) <= 2, 1);
    // silent DRAM: watchdog fires, flag stays set
    for (int k = 0; k < 3 * TO; k++) begin
      drive(1, 1, $urandom_range(1), 0, $urandom, $urandom); cycle();
    end
    chk("err_set", err_timeout, 1);
    for (int k = 0; k < 40; k++) rand_cycle(50, 40, 0);
    chk("err_sticky", err_timeout, 1);
    // broad random traffic with occasional resets and stalls
    for (int k = 0; k < 3000; k++) rand_cycle(55, (k % 400 < 60) ? 0 : 30, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
